// File: rtl/mf8_pcs_stack.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : mf8_pcs_stack
// Purpose  : Program-counter sequencer for the mf8 core with a hardware
//            return stack. One action per cycle, in fixed priority order:
//            Pause > Irq > Ret > Call > RJmp > increment.
// Ports    : Clk, Reset      - clock, synchronous active-high reset
//            Offs_In         - two's-complement offset for RJmp / Call
//            Pause           - stall; holds PC, stack and flags
//            RJmp/Call/Ret   - decoder control strobes
//            Irq             - interrupt entry strobe
//            NPC             - combinational next PC (memory address)
//            PC              - registered current PC
//            SP_Level        - number of valid stack entries
//            Stack_Ovf/Unf   - sticky overflow / underflow flags
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
module mf8_pcs_stack #(
    parameter int PC_W        = 12,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_VEC   = 0,
    parameter int IRQ_VEC     = 1
) (
    input  logic                               Clk,
    input  logic                               Reset,
    input  logic [PC_W-1:0]                    Offs_In,
    input  logic                               Pause,
    input  logic                               RJmp,
    input  logic                               Call,
    input  logic                               Ret,
    input  logic                               Irq,
    output logic [PC_W-1:0]                    NPC,
    output logic [PC_W-1:0]                    PC,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   SP_Level,
    output logic                               Stack_Ovf,
    output logic                               Stack_Unf
);

    localparam int              c_lvl_w     = $clog2(STACK_DEPTH + 1);
    localparam logic [PC_W-1:0] c_reset_vec = PC_W'(RESET_VEC);
    localparam logic [PC_W-1:0] c_irq_vec   = PC_W'(IRQ_VEC);
    localparam logic [PC_W-1:0] c_one       = PC_W'(1);
    localparam logic [c_lvl_w-1:0] c_full   = c_lvl_w'(STACK_DEPTH);
    localparam logic [c_lvl_w-1:0] c_empty  = '0;
    localparam logic [c_lvl_w-1:0] c_lvl_one = c_lvl_w'(1);

    // Index 0 is always the top of stack; deeper entries are older. A push
    // shifts everything one place deeper, so on a full stack the oldest
    // entry naturally falls off the end.
    logic [PC_W-1:0]    r_stack [STACK_DEPTH];
    logic [PC_W-1:0]    r_pc;
    logic [c_lvl_w-1:0] r_level;
    logic               r_ovf;
    logic               r_unf;

    logic [PC_W-1:0]    w_npc;
    logic [PC_W-1:0]    w_push_val;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;

    assign w_full  = (r_level == c_full);
    assign w_empty = (r_level == c_empty);

    //------------------------------------------------------------------
    // Next-PC selection and stack strobes
    //------------------------------------------------------------------
    always_comb begin
        w_npc      = r_pc + c_one;
        w_push_val = '0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        if (Pause) begin
            w_npc = r_pc;
        end else if (Irq) begin
            // Push the current PC so the interrupted instruction re-runs.
            w_npc      = c_irq_vec;
            w_push     = 1'b1;
            w_push_val = r_pc;
        end else if (Ret) begin
            w_pop = 1'b1;
            w_npc = w_empty ? c_reset_vec : r_stack[0];
        end else if (Call) begin
            w_npc      = r_pc + Offs_In;
            w_push     = 1'b1;
            w_push_val = r_pc + c_one;
        end else if (RJmp) begin
            // Modulo-2^PC_W add is identical for signed and unsigned offsets.
            w_npc = r_pc + Offs_In;
        end
    end

    //------------------------------------------------------------------
    // PC, level and sticky flags
    //------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc    <= c_reset_vec;
            r_level <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_pc <= w_npc;
            if (w_push) begin
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_level <= r_level + c_lvl_one;
                end
            end else if (w_pop) begin
                if (w_empty) begin
                    r_unf <= 1'b1;
                end else begin
                    r_level <= r_level - c_lvl_one;
                end
            end
        end
    end

    //------------------------------------------------------------------
    // Return-address storage
    //------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else if (w_push) begin
            r_stack[0] <= w_push_val;
            for (int i = 1; i < STACK_DEPTH; i++) begin
                r_stack[i] <= r_stack[i-1];
            end
        end else if (w_pop && !w_empty) begin
            for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                r_stack[i] <= r_stack[i+1];
            end
            r_stack[STACK_DEPTH-1] <= '0;
        end
    end

    assign NPC       = w_npc;
    assign PC        = r_pc;
    assign SP_Level  = r_level;
    assign Stack_Ovf = r_ovf;
    assign Stack_Unf = r_unf;

endmodule
`default_nettype wire

// File: doc/mf8_pcs_stack.md
Name: mf8_pcs_stack

Overview:
- Parametrised program-counter sequencer for the mf8 core, with a hardware return stack.
- Adds relative call, return and interrupt entry on top of increment / relative jump / pause.
- Produces the combinational next-PC (NPC) for instruction-memory addressing and the registered current PC.
- Sits between the decoder (control strobes, offset) and the program memory address port.

Parameters:
- PC_W, 12: program counter width in bits; all PC arithmetic is modulo 2^PC_W.
- STACK_DEPTH, 4: number of return-address entries; minimum 1.
- RESET_VEC, 0: PC value loaded on reset and returned on a stack underflow.
- IRQ_VEC, 1: PC value loaded on interrupt entry.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Offs_In  in  PC_W  two's-complement offset for RJmp/Call.
- Pause  in  1  stall: hold PC and stack.
- RJmp  in  1  relative jump.
- Call  in  1  relative call: push return address, then jump.
- Ret  in  1  return: pop return address.
- Irq  in  1  interrupt entry request (single-cycle strobe from the interrupt controller).
- NPC  out  PC_W  combinational next PC.
- PC  out  PC_W  registered current PC.
- SP_Level  out  clog2(STACK_DEPTH+1)  number of valid stack entries.
- Stack_Ovf  out  1  sticky: a push occurred while full.
- Stack_Unf  out  1  sticky: a pop occurred while empty.

Behaviour:
- Reset has priority over every other input, including mid-operation; it applies at the next rising edge:
  - PC=RESET_VEC, SP_Level=0, Stack_Ovf=0, Stack_Unf=0, all stack entries cleared to 0.
  - NPC is combinational from current state even while Reset is high.
- NPC is combinational from the current PC, the stack and the inputs (zero latency). PC<=NPC every edge when not in reset.
- Exactly one action per cycle, fixed priority, highest first:
  - 1. Pause=1: NPC=PC; stack, SP_Level and flags unchanged; all other strobes ignored and lost.
  - 2. Irq=1: NPC=IRQ_VEC; push PC, so the interrupted instruction re-executes on return.
  - 3. Ret=1: NPC=top entry; pop.
  - 4. Call=1: NPC=PC+Offs_In; push PC+1.
  - 5. RJmp=1: NPC=PC+Offs_In.
  - 6. Otherwise: NPC=PC+1.
- Arithmetic:
  - Offs_In is sign-interpreted, added at PC_W bits; carry discarded.
  - Wrap-around is required, e.g. PC=0xFFF+1 gives 0x000 at PC_W=12.
- Push:
  - Entry written at the top; SP_Level increments.
  - If SP_Level==STACK_DEPTH: the oldest entry is discarded (shift-out), the new entry is still pushed at the top, SP_Level stays STACK_DEPTH, and Stack_Ovf<=1.
- Pop:
  - Top entry is consumed; SP_Level decrements.
  - If SP_Level==0: NPC=RESET_VEC, SP_Level stays 0, Stack_Unf<=1.
- Stack_Ovf and Stack_Unf remain set until Reset; there is no other clear path.
- Simultaneous strobes follow the priority list. Lower-priority strobes in the same cycle have no effect on the stack or on the flags.

Test Plan:
- Reset then free-run with all strobes 0 -> PC sequence 0,1,2,3; NPC=PC+1 each cycle; SP_Level=0.
- Reset asserted for one cycle with PC=0x123 -> next PC=0x000, flags 0; and at PC=0xFFF with no strobes -> PC wraps to 0x000.
- PC=0x010, RJmp=1, Offs_In=0xFFC (-4) -> PC=0x00C; same cycle with Pause=1 -> PC stays 0x010.
- PC=0x020, Call=1, Offs_In=0x030 -> PC=0x050, SP_Level=1. Then Ret=1 -> PC=0x021, SP_Level=0.
- PC=0x040, Irq=1 and Call=1 together -> PC=IRQ_VEC=0x001, SP_Level=1, top=0x040. Then Ret=1 -> PC=0x040.
- Overflow/underflow:
  - Five consecutive Calls at STACK_DEPTH=4 -> SP_Level=4, Stack_Ovf=1.
  - Four Rets return the last four addresses in reverse order.
  - A fifth Ret -> PC=0x000, Stack_Unf=1.
  - Both flags hold until Reset.
